// File: rtl/knn_topk_sorter_if.sv
// Distance-beat stream from the clustered distance units into the top-K sorter.
interface knn_topk_sorter_if #(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned LANES = 2,
  parameter int unsigned IDX_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [SIZE-1:0]  in_dst [LANES];
  logic [IDX_W-1:0] in_idx;
  logic             in_last;

  modport master (
    output in_valid, in_dst, in_idx, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_dst, in_idx, in_last,
    output in_ready
  );
endinterface

// File: rtl/knn_topk_sorter.sv
// KNN top-K sorter: absorbs beats of LANES distances one lane per cycle and
// keeps the K smallest (distance, point index) pairs sorted ascending.
module knn_topk_sorter #(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned LANES = 2,
  parameter int unsigned K     = 3,
  parameter int unsigned IDX_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  knn_topk_sorter_if.slave         strm,
  output logic [SIZE-1:0]          out_dst [K],
  output logic [IDX_W-1:0]         out_idx [K],
  output logic [$clog2(K+1)-1:0]   out_count,
  output logic                     out_valid,
  output logic                     busy
);

  localparam int unsigned CW   = $clog2(K + 1);
  localparam int unsigned LP_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    INSERT,
    DONE
  } state_t;

  state_t state_q, state_d;

  // beat buffer
  logic [SIZE-1:0]  buf_dst [LANES];
  logic [IDX_W-1:0] buf_idx;
  logic             buf_last;
  logic [LP_W-1:0]  ptr_q;

  // sorted list
  logic [SIZE-1:0]  lst_dst [K];
  logic [IDX_W-1:0] lst_idx [K];
  logic [K-1:0]     lst_vld;
  logic [CW-1:0]    cnt_q;

  // control
  logic accept;
  logic do_ins;
  logic clr;

  // insertion datapath
  logic [SIZE-1:0]  cand_d;
  logic [IDX_W-1:0] cand_i;
  logic [SIZE-1:0]  nxt_dst [K];
  logic [IDX_W-1:0] nxt_idx [K];
  logic [K-1:0]     nxt_vld;
  logic             any_hit;
  logic             hit;
  logic             found;
  logic [SIZE-1:0]  prev_d;
  logic [IDX_W-1:0] prev_i;
  logic             prev_v;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs; start overrides everything
  always_comb begin
    state_d       = state_q;
    strm.in_ready = 1'b0;
    out_valid     = 1'b0;
    busy          = 1'b0;
    accept        = 1'b0;
    do_ins        = 1'b0;
    clr           = 1'b0;
    case (state_q)
      IDLE: ;
      COLLECT: begin
        strm.in_ready = 1'b1;
        busy          = 1'b1;
        if (strm.in_valid) begin
          accept  = 1'b1;
          state_d = INSERT;
        end
      end
      INSERT: begin
        busy   = 1'b1;
        do_ins = 1'b1;
        if (ptr_q == LP_W'(LANES - 1))
          state_d = buf_last ? DONE : COLLECT;
      end
      DONE: out_valid = 1'b1;
      default: state_d = IDLE;
    endcase
    if (start) begin
      clr     = 1'b1;
      accept  = 1'b0;
      do_ins  = 1'b0;
      state_d = COLLECT;
    end
  end

  // Candidate lands at the first slot that is empty or holds a strictly
  // larger distance; everything from there down shifts by one slot. The
  // list keeps valid entries as a sorted prefix, so "first hit" suffices.
  always_comb begin
    cand_d  = buf_dst[ptr_q];
    cand_i  = buf_idx + IDX_W'(ptr_q);
    found   = 1'b0;
    hit     = 1'b0;
    prev_d  = '1;
    prev_i  = '0;
    prev_v  = 1'b0;
    for (int unsigned j = 0; j < K; j++) begin
      hit        = !lst_vld[j] || (cand_d < lst_dst[j]);
      nxt_dst[j] = lst_dst[j];
      nxt_idx[j] = lst_idx[j];
      nxt_vld[j] = lst_vld[j];
      if (found) begin
        nxt_dst[j] = prev_d;
        nxt_idx[j] = prev_i;
        nxt_vld[j] = prev_v;
      end else if (hit) begin
        nxt_dst[j] = cand_d;
        nxt_idx[j] = cand_i;
        nxt_vld[j] = 1'b1;
      end
      prev_d = lst_dst[j];
      prev_i = lst_idx[j];
      prev_v = lst_vld[j];
      found  = found | hit;
    end
    any_hit = found;
  end

  // Beat capture and lane pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned l = 0; l < LANES; l++) buf_dst[l] <= '0;
      buf_idx  <= '0;
      buf_last <= 1'b0;
      ptr_q    <= '0;
    end else if (clr) begin
      buf_last <= 1'b0;
      ptr_q    <= '0;
    end else if (accept) begin
      for (int unsigned l = 0; l < LANES; l++) buf_dst[l] <= strm.in_dst[l];
      buf_idx  <= strm.in_idx;
      buf_last <= strm.in_last;
      ptr_q    <= '0;
    end else if (do_ins) begin
      ptr_q <= ptr_q + LP_W'(1);
    end
  end

  // Sorted list update and saturating entry count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned j = 0; j < K; j++) begin
        lst_dst[j] <= '1;
        lst_idx[j] <= '0;
      end
      lst_vld <= '0;
      cnt_q   <= '0;
    end else if (clr) begin
      for (int unsigned j = 0; j < K; j++) begin
        lst_dst[j] <= '1;
        lst_idx[j] <= '0;
      end
      lst_vld <= '0;
      cnt_q   <= '0;
    end else if (do_ins) begin
      for (int unsigned j = 0; j < K; j++) begin
        lst_dst[j] <= nxt_dst[j];
        lst_idx[j] <= nxt_idx[j];
      end
      lst_vld <= nxt_vld;
      if (any_hit && (cnt_q < CW'(K))) cnt_q <= cnt_q + CW'(1);
    end
  end

  assign out_dst   = lst_dst;
  assign out_idx   = lst_idx;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_knn_topk_sorter.sv
// Self-checking bench for knn_topk_sorter (K=3, LANES=2).
module tb_knn_topk_sorter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] out_dst [3];
  logic [7:0]  out_idx [3];
  logic [1:0]  out_count;
  logic        out_valid;
  logic        busy;

  int errors = 0;
  int checks = 0;

  knn_topk_sorter_if #(.SIZE(32), .LANES(2), .IDX_W(8)) bus ();

  knn_topk_sorter #(.SIZE(32), .LANES(2), .K(3), .IDX_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .strm      (bus),
    .out_dst   (out_dst),
    .out_idx   (out_idx),
    .out_count (out_count),
    .out_valid (out_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    int          nb;
    logic [31:0] a0, a1;
    logic [7:0]  ia;
    logic [31:0] b0, b1;
    logic [7:0]  ib;
    logic [31:0] e0, e1, e2;
    logic [7:0]  x0, x1, x2;
    int          ec;
  } vec_t;

  typedef struct {
    logic [31:0] e0, e1, e2;
    logic [7:0]  x0, x1, x2;
    int          ec;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.e0 = v.e0; e.e1 = v.e1; e.e2 = v.e2;
    e.x0 = v.x0; e.x1 = v.x1; e.x2 = v.x2;
    e.ec = v.ec;
    sb.push_back(e);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Offer a beat from a negedge; returns 1 ns after the accepting edge.
  task automatic send_beat(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [7:0] idx, input logic last);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_dst[0] = d0;
    bus.in_dst[1] = d1;
    bus.in_idx    = idx;
    bus.in_last   = last;
    for (int n = 0; n < 20; n++) begin
      if (bus.in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 bus.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got no accept expected accept within 20 cycles", tag);
    end
  endtask

  // Wait (bounded) for out_valid, then compare against the scoreboard head.
  task automatic wait_result(input string tag);
    int   cycles;
    exp_t e;
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(posedge clk);
      #1 cycles++;
    end
    check({tag, "_latency"}, cycles, 2);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard: got empty queue expected one entry", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, "_dst0"}, out_dst[0], e.e0);
    check({tag, "_dst1"}, out_dst[1], e.e1);
    check({tag, "_dst2"}, out_dst[2], e.e2);
    check({tag, "_idx0"}, {24'd0, out_idx[0]}, {24'd0, e.x0});
    check({tag, "_idx1"}, {24'd0, out_idx[1]}, {24'd0, e.x1});
    check({tag, "_idx2"}, {24'd0, out_idx[2]}, {24'd0, e.x2});
    check({tag, "_count"}, {30'd0, out_count}, e.ec);
    repeat (3) @(posedge clk);
    #1 check({tag, "_hold"}, {31'd0, out_valid}, 1);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    do_start();
    check({tag, "_ready_after_start"}, {31'd0, bus.in_ready}, 1);
    if (v.nb == 1) begin
      push_exp(v);
      send_beat(tag, v.a0, v.a1, v.ia, 1'b1);
    end else begin
      send_beat(tag, v.a0, v.a1, v.ia, 1'b0);
      push_exp(v);
      send_beat(tag, v.b0, v.b1, v.ib, 1'b1);
    end
    wait_result(tag);
  endtask

  initial begin
    int   acc;
    vec_t v;

    //                 nb  a0    a1  ia   b0  b1  ib   expected dst        expected idx  cnt
    vecs[0] = '{2, 50, 20, 0, 70, 10, 2, 10, 20, 50, 3, 1, 0, 3};         // basic sort
    vecs[1] = '{2, 5, 5, 0, 5, 5, 2, 5, 5, 5, 0, 1, 2, 3};                // ties keep arrival order
    vecs[2] = '{1, 9, 4, 0, 0, 0, 0, 4, 9, ONES, 1, 0, 0, 2};             // underfill
    vecs[3] = '{1, ONES, 1, 0, 0, 0, 0, 1, ONES, ONES, 1, 0, 0, 2};       // real all-ones distance
    vecs[4] = '{1, 2, 1, 255, 0, 0, 0, 1, 2, ONES, 0, 255, 0, 2};         // index wrap
    vecs[5] = '{2, 1, 2, 10, 3, 0, 12, 0, 1, 2, 13, 10, 11, 3};           // eviction of entry K-1

    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_dst[0] = '0;
    bus.in_dst[1] = '0;
    bus.in_idx   = '0;
    bus.in_last  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset values
    check("rst_ready", {31'd0, bus.in_ready}, 0);
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_count", {30'd0, out_count}, 0);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("rst_dst%0d", j), out_dst[j], ONES);
      check($sformatf("rst_idx%0d", j), {24'd0, out_idx[j]}, 0);
    end

    // in_valid while idle has no effect
    bus.in_valid  = 1'b1;
    bus.in_dst[0] = 32'd3;
    bus.in_last   = 1'b1;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    check("idle_busy", {31'd0, busy}, 0);
    check("idle_count", {30'd0, out_count}, 0);

    // table-driven queries
    for (int t = 0; t < 6; t++) begin
      v = vecs[t];
      run_vec($sformatf("vec%0d", t), v);
    end

    // abort: start during INSERT of the first beat discards it
    do_start();
    send_beat("abort_b0", 32'd100, 32'd200, 8'd0, 1'b0);
    do_start();
    check("abort_ready", {31'd0, bus.in_ready}, 1);
    check("abort_count", {30'd0, out_count}, 0);
    check("abort_dst0", out_dst[0], ONES);
    v = '{1, 7, 3, 0, 0, 0, 0, 3, 7, ONES, 1, 0, 0, 2};
    push_exp(v);
    send_beat("abort_b1", 32'd7, 32'd3, 8'd0, 1'b1);
    wait_result("abort");

    // backpressure: in_valid held across the INSERT cycles yields one accept
    do_start();
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_dst[0] = 32'd40;
    bus.in_dst[1] = 32'd30;
    bus.in_idx    = 8'd0;
    bus.in_last   = 1'b0;
    acc = 0;
    for (int n = 0; n < 3; n++) begin
      if (bus.in_ready) acc++;
      @(posedge clk);
      if (n < 2) @(negedge clk);
    end
    #1 bus.in_valid = 1'b0;
    check("bp_accepts", acc, 1);
    check("bp_ready_again", {31'd0, bus.in_ready}, 1);
    v = '{1, 10, 60, 2, 0, 0, 0, 10, 30, 40, 2, 1, 0, 3};
    push_exp(v);
    send_beat("bp_b1", 32'd10, 32'd60, 8'd2, 1'b1);
    wait_result("bp");

    // asynchronous reset mid-INSERT
    do_start();
    send_beat("rstmid", 32'd30, 32'd40, 8'd0, 1'b0);
    @(posedge clk);
    #2 check("rstmid_pre_count", {30'd0, out_count}, 1);
    rst = 1'b1;
    #1;
    check("rstmid_busy", {31'd0, busy}, 0);
    check("rstmid_ready", {31'd0, bus.in_ready}, 0);
    check("rstmid_valid", {31'd0, out_valid}, 0);
    check("rstmid_count", {30'd0, out_count}, 0);
    check("rstmid_dst0", out_dst[0], ONES);
    check("rstmid_idx0", {24'd0, out_idx[0]}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_idle", {31'd0, busy}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
